sysbus_arbiter: RTL and testbench

- Round-robin arbiter that shares the single main system bus between up to NUM_REQ bus masters, such as I-fetch line fill, D-cache line fill and writeback.
- Each master raises its request line, waits for a grant, then holds its busy line for the whole bus transaction.
- Sits between the masters' abtr_reqcyc/abtr_grant/bus_busy handshakes and the top-level bus mux. Its owner output selects which master drives main_bus_req/reqtag/reqcyc/respack.

---
 rtl/sysbus_arb_pkg.sv | 27 ++
 rtl/sysbus_arbiter_rr_pick.sv | 29 ++
 rtl/sysbus_arbiter.sv | 107 ++++++++++
 tb/tb_sysbus_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sysbus_arb_pkg.sv
// Shared arbiter types and constants for the main system bus.
// Timeout revocation is enabled by defining SYSBUS_ARB_TIMEOUT_EN.
package sysbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWNED   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int DEFAULT_NUM_REQ       = 4;
  localparam int DEFAULT_GRANT_TIMEOUT = 16;

  // Bus master slots on the arbiter request vector
  localparam int MASTER_IFETCH = 0;
  localparam int MASTER_DFILL  = 1;
  localparam int MASTER_WB     = 2;
  localparam int MASTER_SPARE  = 3;

  // Transaction tag fields carried on main_bus_reqtag
  localparam logic       SYSBUS_READ   = 1'b0;
  localparam logic       SYSBUS_WRITE  = 1'b1;
  localparam logic [1:0] SYSBUS_MEMORY = 2'd0;
  localparam logic [1:0] SYSBUS_IO     = 2'd1;

endpackage

// File: rtl/sysbus_arbiter_rr_pick.sv
// Rotating-priority picker: first set request above last_winner, wrapping.
// Purely combinational; the caller registers the result.
module rr_pick #(
  parameter int NUM_REQ     = 4,
  parameter int OWNER_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [OWNER_WIDTH-1:0] last_winner,
  output logic                   valid,
  output logic [OWNER_WIDTH-1:0] winner
);

  logic [OWNER_WIDTH-1:0] idx;

  // Walk from farthest to nearest so the nearest set bit is the final assignment.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = OWNER_WIDTH'((int'(last_winner) + i) % NUM_REQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin owner arbiter for the main system bus (IDLE/GRANT/OWNED/RELEASE).
// Define SYSBUS_ARB_TIMEOUT_EN to revoke grants left unclaimed for GRANT_TIMEOUT cycles.
module sysbus_arbiter
  import sysbus_arb_pkg::*;
#(
  parameter int NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int OWNER_WIDTH   = $clog2(NUM_REQ),
  parameter int GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     abtr_reqcyc,
  input  logic [NUM_REQ-1:0]     bus_busy,
  output logic [NUM_REQ-1:0]     abtr_grant,
  output logic [OWNER_WIDTH-1:0] bus_owner,
  output logic                   bus_owned,
  output logic                   timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GRANT_TIMEOUT < 2) begin : g_param_check
    $error("sysbus_arbiter: unsupported NUM_REQ or GRANT_TIMEOUT");
  end

  arb_state_t             state_reg;
  logic [OWNER_WIDTH-1:0] last_winner_reg;
  logic                   pick_valid;
  logic [OWNER_WIDTH-1:0] pick_winner;

  rr_pick #(
    .NUM_REQ    (NUM_REQ),
    .OWNER_WIDTH(OWNER_WIDTH)
  ) u_rr_pick (
    .req        (abtr_reqcyc),
    .last_winner(last_winner_reg),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

`ifdef SYSBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(GRANT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  logic [CNT_W-1:0] timeout_cnt_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      abtr_grant      <= '0;
      bus_owner       <= '0;
      bus_owned       <= 1'b0;
      last_winner_reg <= OWNER_WIDTH'(NUM_REQ - 1);
`ifdef SYSBUS_ARB_TIMEOUT_EN
      timeout_err     <= 1'b0;
      timeout_cnt_reg <= '0;
`endif
    end else begin
`ifdef SYSBUS_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg  <= GRANT;
            abtr_grant <= NUM_REQ'(1) << pick_winner;
            bus_owner  <= pick_winner;
`ifdef SYSBUS_ARB_TIMEOUT_EN
            timeout_cnt_reg <= '0;
`endif
          end
        end
        GRANT: begin
          // A claim in the same cycle as a request drop still takes the bus.
          if (bus_busy[bus_owner]) begin
            state_reg       <= OWNED;
            abtr_grant      <= '0;
            bus_owned       <= 1'b1;
            last_winner_reg <= bus_owner;
          end else if (!abtr_reqcyc[bus_owner]) begin
            state_reg  <= IDLE;
            abtr_grant <= '0;
          end
`ifdef SYSBUS_ARB_TIMEOUT_EN
          else if (timeout_cnt_reg == CNT_LAST) begin
            state_reg       <= RELEASE;
            abtr_grant      <= '0;
            timeout_err     <= 1'b1;
            last_winner_reg <= bus_owner;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
`endif
        end
        OWNED: begin
          if (!bus_busy[bus_owner]) begin
            state_reg <= RELEASE;
            bus_owned <= 1'b0;
          end
        end
        RELEASE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: grant latency, round robin, abandon, reset, timeout.
module tb_sysbus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] busy;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       owned;
  logic       terr;

  int checks   = 0;
  int failures = 0;

  sysbus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .abtr_reqcyc(req),
    .bus_busy   (busy),
    .abtr_grant (grant),
    .bus_owner  (owner),
    .bus_owned  (owned),
    .timeout_err(terr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("chk %s = %0h", tag, got);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    busy  = 4'b0000;
    step();
    step();
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_owned", 32'(owned), 32'h0);
    check_val("rst_owner", 32'(owner), 32'h0);
    check_val("rst_terr",  32'(terr),  32'h0);
    reset = 1'b0;

    // Single request: one cycle to grant, busy claims, release, turnaround
    req = 4'b0001;
    step();
    check_val("grant_lat", 32'(grant), 32'h1);
    check_val("grant_own", 32'(owner), 32'h0);
    busy = 4'b0001;
    req  = 4'b0000;
    step();
    check_val("claim_owned", 32'(owned), 32'h1);
    check_val("claim_grant", 32'(grant), 32'h0);
    repeat (8) step();
    check_val("own_hold", 32'(owned), 32'h1);
    busy = 4'b0000;
    req  = 4'b0010;
    step();
    check_val("release_owned", 32'(owned), 32'h0);
    check_val("release_grant", 32'(grant), 32'h0);
    step();
    check_val("idle_grant", 32'(grant), 32'h0);
    step();
    check_val("turn_grant", 32'(grant), 32'h2);
    check_val("turn_owner", 32'(owner), 32'h1);

    // Abandoned grant returns to IDLE without ownership
    req = 4'b0000;
    step();
    check_val("abandon_grant", 32'(grant), 32'h0);
    check_val("abandon_owned", 32'(owned), 32'h0);
    req = 4'b0011;
    step();
    check_val("abandon_prio", 32'(grant), 32'h2);
    req = 4'b0000;
    step();

    // All masters requesting: strict rotation 0,1,2,3,0
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int exp_m;
      exp_m = k % 4;
      step();
      check_val($sformatf("rr%0d_grant", k), 32'(grant), 32'(1 << exp_m));
      check_val($sformatf("rr%0d_owner", k), 32'(owner), 32'(exp_m));
      busy = 4'(1 << exp_m);
      for (int c = 0; c < 3; c++) begin
        step();
        check_val($sformatf("rr%0d_busy_owner", k), 32'(owner), 32'(exp_m));
        check_val($sformatf("rr%0d_busy_grant", k), 32'(grant), 32'h0);
      end
      busy = 4'b0000;
      step();
      check_val($sformatf("rr%0d_rel", k), 32'(owned), 32'h0);
      step();
    end

    // Master 2 owns while 0 and 3 wait: 3 is next after release
    req = 4'b0100;
    step();
    check_val("m2_grant", 32'(grant), 32'h4);
    busy = 4'b0100;
    req  = 4'b1101;
    step();
    check_val("m2_owner", 32'(owner), 32'h2);
    step();
    check_val("m2_hold_owner", 32'(owner), 32'h2);
    check_val("m2_hold_grant", 32'(grant), 32'h0);
    busy = 4'b0000;
    step();
    step();
    step();
    check_val("after_m2_grant", 32'(grant), 32'h8);
    check_val("after_m2_owner", 32'(owner), 32'h3);
    req = 4'b0001;
    step();
    check_val("m3_abandon", 32'(grant), 32'h0);
    step();
    check_val("m0_grant", 32'(grant), 32'h1);

    // Reset in OWNED with busy held
    busy = 4'b0001;
    step();
    check_val("pre_rst_owned", 32'(owned), 32'h1);
    reset = 1'b1;
    step();
    check_val("midrst_grant", 32'(grant), 32'h0);
    check_val("midrst_owned", 32'(owned), 32'h0);
    reset = 1'b0;
    req   = 4'b0010;
    step();
    check_val("post_rst_grant", 32'(grant), 32'h2);
    req  = 4'b0000;
    busy = 4'b0000;
    step();

    // Unclaimed grant to master 2 with master 0 also pending
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b0100;
    step();
    check_val("to_grant", 32'(grant), 32'h4);
    req = 4'b0101;
`ifdef SYSBUS_ARB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      step();
      check_val($sformatf("to_wait%0d_terr", i), 32'(terr), 32'h0);
    end
    check_val("to_wait_grant", 32'(grant), 32'h4);
    step();
    check_val("to_revoke_grant", 32'(grant), 32'h0);
    check_val("to_revoke_terr", 32'(terr), 32'h1);
    step();
    check_val("to_pulse_end", 32'(terr), 32'h0);
    check_val("to_idle_grant", 32'(grant), 32'h0);
    step();
    check_val("to_next_grant", 32'(grant), 32'h1);
`else
    for (int i = 1; i <= 20; i++) begin
      step();
      check_val($sformatf("nto_wait%0d_terr", i), 32'(terr), 32'h0);
    end
    check_val("nto_grant_held", 32'(grant), 32'h4);
`endif
    req = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
